// File: rtl/sm_step_scheduler.sv
// Step-burst scheduler: turns each ADC sample into a bounded, paced drv_step burst.
// Optional sample watchdog with FAULT state when SM_TIMEOUT_EN is defined.
module sm_step_scheduler #(
  parameter int unsigned WIDTH_IN   = 12,
  parameter int unsigned WIDTH_WORK = 16,
  parameter int unsigned PER_FAR    = 50,
  parameter int unsigned PER_MID    = 500,
  parameter int unsigned PER_NEAR   = 5000,
  parameter int unsigned PULSE_W    = 10,
  parameter int unsigned DIR_SETUP  = 25,
  parameter int unsigned MAX_BURST  = 255,
  parameter int unsigned DEADBAND   = 2,
  parameter int unsigned TIMEOUT    = 500000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                data_valid,
  input  logic [WIDTH_IN-1:0] x,
  input  logic [WIDTH_IN-1:0] x0,
  input  logic [WIDTH_IN-1:0] dx1,
  input  logic [WIDTH_IN-1:0] dx2,
  output logic                drv_enable,
  output logic                drv_dir,
  output logic                drv_step,
  output logic                busy,
  output logic                done,
  output logic                fault
);

  localparam int unsigned MagW = WIDTH_IN + 1;

`ifdef SM_TIMEOUT_EN
  typedef enum logic [2:0] {StIdle, StEval, StDirWait, StStepHi, StStepLo, StFault} state_e;
`else
  typedef enum logic [2:0] {StIdle, StEval, StDirWait, StStepHi, StStepLo} state_e;
`endif

  state_e                state_q, state_d;
  logic                  dv_meta_q, dv_sync_q, dv_prev_q, dv_rise_q;
  logic [WIDTH_IN-1:0]   x_q, x_d, x0_q, x0_d;
  logic [WIDTH_WORK-1:0] cnt_q, cnt_d, steps_q, steps_d, period_q, period_d;
  logic                  dir_q, dir_d, en_q, en_d, done_q, done_d, done_eval;
  logic                  wd_expired;

  logic signed [MagW-1:0] diff;
  logic [MagW-1:0]        mag;
  logic                   dir_new, in_dead;
  logic [WIDTH_WORK-1:0]  steps_eval, period_eval;

  assign diff        = $signed({1'b0, x_q}) - $signed({1'b0, x0_q});
  assign dir_new     = diff[MagW-1];
  assign mag         = dir_new ? $unsigned(-diff) : $unsigned(diff);
  assign in_dead     = (mag <= MagW'(DEADBAND));
  assign steps_eval  = (mag > MagW'(MAX_BURST)) ? WIDTH_WORK'(MAX_BURST) : WIDTH_WORK'(mag);
  // Far test first so it still wins when dx1 > dx2.
  assign period_eval = (mag >= {1'b0, dx2}) ? WIDTH_WORK'(PER_FAR) :
                       (mag >= {1'b0, dx1}) ? WIDTH_WORK'(PER_MID) : WIDTH_WORK'(PER_NEAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_meta_q <= 1'b0;
      dv_sync_q <= 1'b0;
      dv_prev_q <= 1'b0;
      dv_rise_q <= 1'b0;
    end else begin
      dv_meta_q <= data_valid;
      dv_sync_q <= dv_meta_q;
      dv_prev_q <= dv_sync_q;
      dv_rise_q <= dv_sync_q & ~dv_prev_q;
    end
  end

`ifdef SM_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT + 1);
  logic [WdW-1:0] wd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else if (!enable || dv_rise_q || state_q == StFault) begin
      wd_q <= '0;
    end else if (wd_q != WdW'(TIMEOUT)) begin
      wd_q <= wd_q + WdW'(1);
    end
  end

  assign wd_expired = enable && (wd_q == WdW'(TIMEOUT)) && (state_q != StFault);
  assign fault      = (state_q == StFault);
`else
  assign wd_expired = 1'b0;
  assign fault      = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    x0_d      = x0_q;
    cnt_d     = cnt_q;
    steps_d   = steps_q;
    period_d  = period_q;
    dir_d     = dir_q;
    done_d    = 1'b0;
    done_eval = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (dv_rise_q && enable) begin
          x_d     = x;
          x0_d    = x0;
          state_d = StEval;
        end
      end
      StEval: begin
        cnt_d = '0;
        if (in_dead) begin
          done_eval = 1'b1;
          state_d   = StIdle;
        end else begin
          steps_d  = steps_eval;
          period_d = period_eval;
          if (dir_new != dir_q) begin
            dir_d   = dir_new;
            state_d = StDirWait;
          end else begin
            state_d = StStepHi;
          end
        end
      end
      StDirWait: begin
        if (cnt_q == WIDTH_WORK'(DIR_SETUP - 1)) begin
          cnt_d   = '0;
          state_d = StStepHi;
        end else begin
          cnt_d = cnt_q + WIDTH_WORK'(1);
        end
      end
      StStepHi: begin
        if (cnt_q == WIDTH_WORK'(PULSE_W - 1)) begin
          cnt_d   = '0;
          steps_d = steps_q - WIDTH_WORK'(1);
          state_d = StStepLo;
        end else begin
          cnt_d = cnt_q + WIDTH_WORK'(1);
        end
      end
      StStepLo: begin
        if (cnt_q == period_q - WIDTH_WORK'(PULSE_W + 1)) begin
          cnt_d = '0;
          if (steps_q == '0) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StStepHi;
          end
        end else begin
          cnt_d = cnt_q + WIDTH_WORK'(1);
        end
      end
`ifdef SM_TIMEOUT_EN
      StFault: begin
        if (!enable) state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase

    // Dropping enable abandons the burst silently; also how FAULT is left.
    if (!enable && state_q != StIdle) begin
      state_d   = StIdle;
      cnt_d     = '0;
      done_d    = 1'b0;
      done_eval = 1'b0;
    end
`ifdef SM_TIMEOUT_EN
    if (wd_expired) begin
      state_d   = StFault;
      cnt_d     = '0;
      done_d    = 1'b0;
      done_eval = 1'b0;
    end
    en_d = enable && (state_d != StFault);
`else
    en_d = enable && !wd_expired;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      x_q      <= '0;
      x0_q     <= '0;
      cnt_q    <= '0;
      steps_q  <= '0;
      period_q <= '0;
      dir_q    <= 1'b0;
      en_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      x0_q     <= x0_d;
      cnt_q    <= cnt_d;
      steps_q  <= steps_d;
      period_q <= period_d;
      dir_q    <= dir_d;
      en_q     <= en_d;
      done_q   <= done_d;
    end
  end

  assign drv_enable = en_q;
  assign drv_dir    = dir_q;
  assign drv_step   = (state_q == StStepHi);
  assign busy       = (state_q == StDirWait) || (state_q == StStepHi) || (state_q == StStepLo);
  assign done       = done_q | done_eval;

endmodule
